pipe_accumulator: RTL
=====================

PIPE_ACCUMULATOR -- requirements
Module: pipe_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning accumulator and data width in bits.
REQ-002 SHALL have parameter LANES, default 4, meaning pipeline stage count; WIDTH mod LANES == 0; slice width SW = WIDTH/LANES.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  sample D is presented this cycle.
REQ-006 SHALL have port clr  input  1  restart accumulation from zero.
REQ-007 SHALL have port add_sub  input  1  operation: 0 = add, 1 = subtract.
REQ-008 SHALL have port D  input  WIDTH  unsigned operand.
REQ-009 SHALL have port Q  output  WIDTH  accumulated value, registered.
REQ-010 SHALL have port out_valid  output  1  Q reflects a newly accumulated sample.
REQ-011 SHALL have port ovf  output  1  carry-out (add) or borrow-out (sub) of the sample reported with out_valid.

Function
REQ-012 SHALL split the accumulator into LANES slices of SW bits; stage k owns slice k (stage 0 = LSB).
REQ-013 SHALL carry each sample's operand, add_sub, clr, in_valid and the inter-slice carry/borrow down the pipeline in registers.
REQ-014 SHALL make stage k compute slice_k <= base +/- D_slice_k +/- carry_in (carry_in = 0 at stage 0); base = 0 when the sample's clr = 1, else the current slice_k.
REQ-015 SHALL assert out_valid exactly LANES cycles after a cycle with in_valid = 1; Q shall equal the full updated sum on that cycle.
REQ-016 SHALL accept a new sample every cycle with no throughput loss; back-to-back samples shall see each other's results exactly as in non-pipelined accumulation.
REQ-017 SHALL leave all slices unchanged when a stage holds a bubble (in_valid = 0, clr = 0); out_valid = 0 for bubbles.
REQ-018 SHALL zero each slice as a bubble with clr = 1 (in_valid = 0) passes; Q reads 0 LANES cycles later with out_valid = 0 and ovf = 0.
REQ-019 SHALL wrap modulo 2^WIDTH; ovf = carry/borrow out of the top slice for that sample, and ovf = 0 whenever out_valid = 0.
REQ-020 SHALL ignore add_sub when in_valid = 0.
REQ-021 SHALL, for clr = 1 with in_valid = 1, produce Q = 0 + D (add) or 0 - D mod 2^WIDTH (sub); ovf = 1 for subtract when D != 0.
REQ-022 SHALL hold Q between updates.
REQ-023 SHALL be correct for LANES = 1 (single-stage, latency 1) and LANES = WIDTH (1-bit slices).

Reset
REQ-024 SHALL, while rst = 1, force all slices, carries and pipeline registers to 0; Q = 0, out_valid = 0, ovf = 0, asynchronously.
REQ-025 SHALL discard all in-flight samples on reset; after rst deasserts, out_valid shall not assert until LANES cycles after the first post-reset in_valid.

Verification (WIDTH = 16, LANES = 4 unless noted)
REQ-026 SHALL pass: reset; in_valid add 0x1234 then add 0x0001 on consecutive cycles -> out_valid on cycles +4 and +5, Q = 0x1234 then 0x1235, ovf = 0.
REQ-027 SHALL pass: clr+add 0x00FF, add 0x0001, add 0xFEFF, add 0x0001 back-to-back -> Q = 0x00FF, 0x0100, 0xFFFF, 0x0000; ovf = 1 only on the last.
REQ-028 SHALL pass: clr+sub 0x0001 -> Q = 0xFFFF, ovf = 1; next add 0x0002 -> Q = 0x0001, ovf = 1.
REQ-029 SHALL pass: valid add 3, three idle cycles, clr bubble, idle, valid add 5 -> out_valid pattern equals in_valid delayed 4; Q = 3, then 0 (out_valid = 0), then 5.
REQ-030 SHALL pass: rst pulse while three samples in flight -> Q = 0, out_valid stays 0, and no stale samples emerge afterwards.
REQ-031 SHALL pass: scenarios REQ-026 to REQ-028 repeated with LANES = 1 and LANES = 8 -> same Q/ovf sequences, latency = LANES.

Source files
------------

// File: rtl/pipe_accumulator.sv
// Carry-pipelined accumulator: stage k owns slice k of the running sum.
// Each sample walks up the slices one stage per cycle with its carry.
module pipe_accumulator #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             clr,
    input  logic             add_sub,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             out_valid,
    output logic             ovf
);
    localparam int SW = WIDTH / LANES;

    // Stage inputs: index 0 is the ports, index k > 0 is the link register
    logic             vld_l [LANES];
    logic             clr_l [LANES];
    logic             sub_l [LANES];
    logic             cy_l  [LANES];
    logic [WIDTH-1:0] d_l   [LANES];
    logic [WIDTH-1:0] res_l [LANES];

    logic             cy_o  [LANES];
    logic [WIDTH-1:0] res_o [LANES];

    assign vld_l[0] = in_valid;
    assign clr_l[0] = clr;
    assign sub_l[0] = add_sub;
    assign cy_l[0]  = 1'b0;
    assign d_l[0]   = D;
    assign res_l[0] = '0;

    for (genvar k = 0; k < LANES; k++) begin : g_stage
        logic [SW-1:0]    slice_q, slice_d, base, opnd;
        logic [SW:0]      cin, sum;
        logic             cy;
        logic [WIDTH-1:0] res;

        always_comb begin
            base = clr_l[k] ? '0 : slice_q;
            opnd = d_l[k][k*SW +: SW];
            cin  = {{SW{1'b0}}, cy_l[k]};
            if (sub_l[k]) sum = {1'b0, base} - {1'b0, opnd} - cin;
            else          sum = {1'b0, base} + {1'b0, opnd} + cin;
            slice_d = slice_q;
            if (vld_l[k])      slice_d = sum[SW-1:0];
            else if (clr_l[k]) slice_d = '0;
            cy  = vld_l[k] & sum[SW];
            res = res_l[k];
            res[k*SW +: SW] = slice_d;
        end

        assign cy_o[k]  = cy;
        assign res_o[k] = res;

        always_ff @(posedge clock or posedge rst) begin
            if (rst) slice_q <= '0;
            else     slice_q <= slice_d;
        end

        // The sample's lower result slices travel with it so Q is never skewed
        if (k < LANES - 1) begin : g_link
            logic             vld_q, clr_q, sub_q, cy_q;
            logic             vld_d, clr_d, sub_d, cy_d;
            logic [WIDTH-1:0] d_q, res_q, d_d, res_d;

            always_comb begin
                vld_d = vld_l[k];
                clr_d = clr_l[k];
                sub_d = sub_l[k];
                cy_d  = cy;
                d_d   = d_l[k];
                res_d = res;
            end

            always_ff @(posedge clock or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    clr_q <= 1'b0;
                    sub_q <= 1'b0;
                    cy_q  <= 1'b0;
                    d_q   <= '0;
                    res_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    clr_q <= clr_d;
                    sub_q <= sub_d;
                    cy_q  <= cy_d;
                    d_q   <= d_d;
                    res_q <= res_d;
                end
            end

            assign vld_l[k+1] = vld_q;
            assign clr_l[k+1] = clr_q;
            assign sub_l[k+1] = sub_q;
            assign cy_l[k+1]  = cy_q;
            assign d_l[k+1]   = d_q;
            assign res_l[k+1] = res_q;
        end
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        q_d = q_q;
        if (vld_l[LANES-1] || clr_l[LANES-1]) q_d = res_o[LANES-1];
        out_valid_d = vld_l[LANES-1];
        ovf_d       = cy_o[LANES-1];
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            q_q         <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            q_q         <= q_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign Q         = q_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
endmodule
